// File: rtl/day_counter.sv
// rtl/day_counter.sv - day-of-year BCD counter stepped by debounced, auto-repeating up/down buttons
//
// Ports:
//   clk       system clock, all state changes on the rising edge
//   reset     asynchronous active-high reset (count returns to 01)
//   btn_up    raw up pushbutton, active-high, asynchronous to clk
//   btn_down  raw down pushbutton, active-high, asynchronous to clk
//   counter10 BCD tens digit of the day-of-year (0..9)
//   counter1  BCD units digit of the day-of-year (0..9)
//   wrap      one-cycle pulse, coincident with the new count, on 99->01 or 01->99

module day_counter #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000,
    parameter int CNT_W           = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [3:0] counter10,
    output logic [3:0] counter1,
    output logic       wrap
);

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // Button index 0 is up, 1 is down; dir uses the same encoding.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2,
        LOCK   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input path: 2-flop synchroniser and debounce, one lane per button
    // ------------------------------------------------------------------
    logic [1:0]            btn_raw;
    logic [1:0]            sync1_q, sync1_d;
    logic [1:0]            sync2_q, sync2_d;
    logic [1:0]            deb_q, deb_d;
    logic [1:0][CNT_W-1:0] db_cnt_q, db_cnt_d;

    assign btn_raw = {btn_down, btn_up};

    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        deb_d    = deb_q;
        db_cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            // Any cycle where the synchronised level agrees with the
            // debounced level restarts the count, so short glitches vanish.
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    deb_d[i]    = sync2_q[i];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            deb_q    <= '0;
            db_cnt_q <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            deb_q    <= deb_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Step FSM: first step on press, auto-repeat while held, lock-out
    // while both buttons are down
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             step;
    logic             step_dir;
    logic             both_held;
    logic             any_held;
    logic             active_held;

    assign both_held   = deb_q[0] & deb_q[1];
    assign any_held    = deb_q[0] | deb_q[1];
    assign active_held = deb_q[dir_q];

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        timer_d  = timer_q;
        step     = 1'b0;
        step_dir = dir_q;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                // IDLE is only entered with no button held (or with the
                // other button just rising), so a held level here is a rise.
                if (both_held) begin
                    state_d = LOCK;
                end else if (deb_q[0]) begin
                    step     = 1'b1;
                    step_dir = DIR_UP;
                    dir_d    = DIR_UP;
                    state_d  = DELAY;
                end else if (deb_q[1]) begin
                    step     = 1'b1;
                    step_dir = DIR_DOWN;
                    dir_d    = DIR_DOWN;
                    state_d  = DELAY;
                end
            end
            DELAY, REPEAT: begin
                // Order matters: lock-out, then release, then expiry, so a
                // release coinciding with expiry produces no step.
                if (both_held) begin
                    state_d = LOCK;
                    timer_d = '0;
                end else if (!active_held) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if ((state_q == DELAY  && timer_q == DELAY_LAST) ||
                             (state_q == REPEAT && timer_q == RATE_LAST)) begin
                    step    = 1'b1;
                    timer_d = '0;
                    state_d = REPEAT;
                end else begin
                    timer_d = timer_q + CNT_ONE;
                end
            end
            LOCK: begin
                timer_d = '0;
                if (!any_held) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            dir_q   <= DIR_UP;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            timer_q <= timer_d;
        end
    end

    // ------------------------------------------------------------------
    // BCD step arithmetic over 01..99; 00 is skipped by wrapping
    // ------------------------------------------------------------------
    logic [3:0] tens_q, tens_d;
    logic [3:0] units_q, units_d;
    logic       wrap_q, wrap_d;

    always_comb begin
        tens_d  = tens_q;
        units_d = units_q;
        wrap_d  = 1'b0;
        if (step) begin
            if (step_dir == DIR_UP) begin
                if (tens_q == 4'd9 && units_q == 4'd9) begin
                    tens_d  = 4'd0;
                    units_d = 4'd1;
                    wrap_d  = 1'b1;
                end else if (units_q == 4'd9) begin
                    units_d = 4'd0;
                    tens_d  = tens_q + 4'd1;
                end else begin
                    units_d = units_q + 4'd1;
                end
            end else begin
                if (tens_q == 4'd0 && units_q == 4'd1) begin
                    tens_d  = 4'd9;
                    units_d = 4'd9;
                    wrap_d  = 1'b1;
                end else if (units_q == 4'd0) begin
                    units_d = 4'd9;
                    tens_d  = tens_q - 4'd1;
                end else begin
                    units_d = units_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tens_q  <= 4'd0;
            units_q <= 4'd1;
            wrap_q  <= 1'b0;
        end else begin
            tens_q  <= tens_d;
            units_q <= units_d;
            wrap_q  <= wrap_d;
        end
    end

    assign counter10 = tens_q;
    assign counter1  = units_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_day_counter.sv
// tb/tb_day_counter.sv - directed self-checking bench for day_counter

module tb_day_counter;

    logic       clk;
    logic       reset;
    logic       btn_up;
    logic       btn_down;
    logic [3:0] counter10;
    logic [3:0] counter1;
    logic       wrap;

    int total;
    int passed;
    int wrap_cnt;

    day_counter #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_RATE    (5),
        .CNT_W          (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .counter10(counter10),
        .counter1 (counter1),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wrap === 1'b1) wrap_cnt = wrap_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total = total + 1;
        assert (obs === exp) begin
            passed = passed + 1;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input bit up, input int hold);
        if (up) btn_up = 1'b1; else btn_down = 1'b1;
        tick(hold);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        tick(12);
    endtask

    initial begin
        total    = 0;
        passed   = 0;
        wrap_cnt = 0;
        reset    = 1'b1;
        btn_up   = 1'b0;
        btn_down = 1'b0;

        // Reset state
        tick(3);
        check("reset_value", {counter10, counter1}, 8'h01);
        check("reset_wrap", {7'd0, wrap}, 8'h00);
        reset = 1'b0;
        tick(100);
        check("idle_value", {counter10, counter1}, 8'h01);
        check("idle_wrap_cnt", 8'(wrap_cnt), 8'h00);

        // Single press: lands 7 edges after the raw edge, no repeat before release
        btn_up = 1'b1;
        tick(6);
        check("first_step_early", {counter10, counter1}, 8'h01);
        tick(1);
        check("first_step", {counter10, counter1}, 8'h02);
        tick(3);
        btn_up = 1'b0;
        tick(25);
        check("no_repeat_after_release", {counter10, counter1}, 8'h02);

        // Tens carry and borrow
        for (int i = 0; i < 7; i++) pulse(1'b1, 10);
        check("count_to_09", {counter10, counter1}, 8'h09);
        pulse(1'b1, 10);
        check("carry_09_10", {counter10, counter1}, 8'h10);
        pulse(1'b0, 10);
        check("borrow_10_09", {counter10, counter1}, 8'h09);

        // Glitches shorter than the debounce window
        for (int i = 0; i < 5; i++) begin
            btn_up = 1'b1;
            tick(3);
            btn_up = 1'b0;
            tick(4);
        end
        tick(10);
        check("glitch_no_step", {counter10, counter1}, 8'h09);

        // Asynchronous reset, then reset mid-hold at 05
        #3 reset = 1'b1;
        #1 check("async_reset", {counter10, counter1}, 8'h01);
        tick(2);
        reset = 1'b0;
        tick(2);
        for (int i = 0; i < 3; i++) pulse(1'b1, 10);
        btn_up = 1'b1;
        tick(7);
        check("reach_05", {counter10, counter1}, 8'h05);
        tick(3);
        #3 reset = 1'b1;
        #1 check("reset_mid_hold", {counter10, counter1}, 8'h01);
        tick(2);
        reset = 1'b0;
        tick(6);
        check("rearm_no_early_step", {counter10, counter1}, 8'h01);
        tick(1);
        check("rearm_fresh_step", {counter10, counter1}, 8'h02);
        btn_up = 1'b0;
        tick(12);

        // Down wrap 01 -> 99, then down to 98
        #3 reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        pulse(1'b0, 10);
        check("down_wrap_value", {counter10, counter1}, 8'h99);
        check("down_wrap_cnt", 8'(wrap_cnt), 8'h01);
        pulse(1'b0, 10);
        check("down_to_98", {counter10, counter1}, 8'h98);

        // Hold up from 98: 99, then 01 (+20, wrap), 02 (+25), 03 (+30)
        btn_up = 1'b1;
        tick(7);
        check("hold_first_99", {counter10, counter1}, 8'h99);
        tick(19);
        check("hold_delay_boundary", {counter10, counter1}, 8'h99);
        tick(1);
        check("hold_wrap_01", {counter10, counter1}, 8'h01);
        check("hold_wrap_pulse", {7'd0, wrap}, 8'h01);
        tick(1);
        check("hold_wrap_one_cycle", {7'd0, wrap}, 8'h00);
        tick(4);
        check("hold_repeat_02", {counter10, counter1}, 8'h02);
        check("hold_wrap_cnt", 8'(wrap_cnt), 8'h02);
        tick(5);
        check("hold_repeat_03", {counter10, counter1}, 8'h03);

        // Down pressed mid-REPEAT: one more scheduled step, then frozen
        btn_down = 1'b1;
        tick(13);
        check("lock_entry", {counter10, counter1}, 8'h04);
        tick(20);
        check("lock_both_held", {counter10, counter1}, 8'h04);
        btn_down = 1'b0;
        tick(30);
        check("lock_up_only", {counter10, counter1}, 8'h04);
        btn_up = 1'b0;
        tick(15);
        check("lock_released", {counter10, counter1}, 8'h04);

        // Both buttons debounce in the same cycle from IDLE
        btn_up   = 1'b1;
        btn_down = 1'b1;
        tick(30);
        check("simultaneous_no_step", {counter10, counter1}, 8'h04);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        tick(15);
        check("simultaneous_release", {counter10, counter1}, 8'h04);
        pulse(1'b0, 10);
        check("after_lock_down", {counter10, counter1}, 8'h03);
        check("final_wrap_cnt", 8'(wrap_cnt), 8'h02);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
